cmp_sweep_ctrl: RTL and testbench

- Sequencer for the 2-bit magnitude-comparator/RGB LED datapath.
- Idle (manual) mode: registers switch operands into the comparator and latches the comparator's RGB result onto the LEDs.
- On `start`: sweeps every (a,b) operand pair in ascending order, holding each result on the LEDs for a programmable dwell time, then pulses `done`.
- Sits between board switches/buttons and the external combinational comparator.

---
 rtl/cmp_sweep_pkg.sv | 30 +++
 rtl/cmp_sweep_ctrl_dwell_timer.sv | 37 +++
 rtl/cmp_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cmp_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_sweep_pkg.sv
// Shared types and the reference comparator function for the comparator sweep sequencer.
// Used by cmp_sweep_ctrl (optional CMP_SWEEP_CHECK_EN checker) and by its testbench.
package cmp_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DWELL,
        DONE
    } state_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    // Operands are zero-extended to this width at the call site so one function serves any WIDTH.
    localparam int OPND_W_MAX = 16;

    function automatic rgb_t exp_rgb(input logic [OPND_W_MAX-1:0] a,
                                     input logic [OPND_W_MAX-1:0] b);
        rgb_t res;
        res.r = (a >= b);
        res.g = (a <= b);
        res.b = (a != b);
        return res;
    endfunction

endpackage

// File: rtl/cmp_sweep_ctrl_dwell_timer.sv
// Per-pair dwell counter: cleared outside DWELL, counts while enabled, flags the last dwell cycle.
module dwell_timer #(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign expire = enable && (count_reg == LAST);

    // Holding at LAST instead of incrementing keeps the counter from ever wrapping.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expire) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/cmp_sweep_ctrl.sv
// Manual/sweep sequencer driving an external combinational 2-operand comparator and RGB LEDs.
// Optional result checker and check_err port are built when CMP_SWEEP_CHECK_EN is defined.
module cmp_sweep_ctrl
    import cmp_sweep_pkg::*;
#(
    parameter int WIDTH        = 2,
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   sw_a,
    input  logic [WIDTH-1:0]   sw_b,
    input  logic               cmp_red,
    input  logic               cmp_green,
    input  logic               cmp_blue,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               led_r,
    output logic               led_g,
    output logic               led_b,
    output logic               busy,
    output logic               done,
`ifdef CMP_SWEEP_CHECK_EN
    output logic               check_err,
`endif
    output logic [2*WIDTH-1:0] pair_idx
);
    localparam int PAIR_W = 2 * WIDTH;

    state_e             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [2:0]         led_reg, led_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [2:0]         cmp_vec;
    logic [PAIR_W-1:0]  pair_inc;
    logic               expire;

    assign cmp_vec  = {cmp_red, cmp_green, cmp_blue};
    assign pair_inc = {a_reg, b_reg} + PAIR_W'(1);

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_reg != DWELL),
        .enable (state_reg == DWELL),
        .expire (expire)
    );

`ifdef CMP_SWEEP_CHECK_EN
    logic chk_reg, chk_next;
    rgb_t chk_exp;

    assign chk_exp = exp_rgb(OPND_W_MAX'(a_reg), OPND_W_MAX'(b_reg));
`endif

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        led_next   = led_reg;
`ifdef CMP_SWEEP_CHECK_EN
        chk_next   = chk_reg;
`endif
        case (state_reg)
            IDLE: begin
                a_next   = sw_a;
                b_next   = sw_b;
                led_next = cmp_vec;
                if (start && !stop) begin
                    a_next     = '0;
                    b_next     = '0;
                    led_next   = led_reg;
                    state_next = SETTLE;
`ifdef CMP_SWEEP_CHECK_EN
                    chk_next   = 1'b0;
`endif
                end
            end
            SETTLE: begin
                led_next   = cmp_vec;
                state_next = DWELL;
`ifdef CMP_SWEEP_CHECK_EN
                if (cmp_vec != chk_exp) begin
                    chk_next = 1'b1;
                end
`endif
            end
            DWELL: begin
                if (expire) begin
                    if (&{a_reg, b_reg}) begin
                        state_next = DONE;
                    end else begin
                        {a_next, b_next} = pair_inc;
                        state_next       = SETTLE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort from any active state; operands hold, LEDs blank.
        if (stop && (state_reg != IDLE)) begin
            state_next = IDLE;
            a_next     = a_reg;
            b_next     = b_reg;
            led_next   = '0;
        end

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_led
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    led_reg[gi] <= 1'b0;
                end else begin
                    led_reg[gi] <= led_next[gi];
                end
            end
        end
    endgenerate

`ifdef CMP_SWEEP_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_reg <= 1'b0;
        end else begin
            chk_reg <= chk_next;
        end
    end

    assign check_err = chk_reg;
`endif

    assign a_out    = a_reg;
    assign b_out    = b_reg;
    assign led_r    = led_reg[2];
    assign led_g    = led_reg[1];
    assign led_b    = led_reg[0];
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign pair_idx = {a_reg, b_reg};

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Self-checking bench for cmp_sweep_ctrl (WIDTH=2, DWELL_CYCLES=4) with a behavioural comparator.
// Exercises the CMP_SWEEP_CHECK_EN checker when that macro is defined.
module tb_cmp_sweep_ctrl;

    localparam int WIDTH = 2;
    localparam int DWELL = 4;
    localparam int NPAIR = 16;
    localparam int PAIR_CYC = DWELL + 1;
    localparam int SWEEP_CYC = NPAIR * PAIR_CYC + 1;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [1:0] sw_a;
    logic [1:0] sw_b;
    logic       cmp_red, cmp_green, cmp_blue;
    logic [1:0] a_out, b_out;
    logic       led_r, led_g, led_b;
    logic       busy, done;
    logic [3:0] pair_idx;
`ifdef CMP_SWEEP_CHECK_EN
    logic       check_err;
`endif
    logic [2:0] leds;
    logic       corrupt_en;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] rgb;
    } vec_t;

    vec_t vecs[6];
    logic [2:0] sb[$];

    cmp_sweep_ctrl #(
        .WIDTH(WIDTH),
        .DWELL_CYCLES(DWELL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .sw_a     (sw_a),
        .sw_b     (sw_b),
        .cmp_red  (cmp_red),
        .cmp_green(cmp_green),
        .cmp_blue (cmp_blue),
        .a_out    (a_out),
        .b_out    (b_out),
        .led_r    (led_r),
        .led_g    (led_g),
        .led_b    (led_b),
        .busy     (busy),
        .done     (done),
`ifdef CMP_SWEEP_CHECK_EN
        .check_err(check_err),
`endif
        .pair_idx (pair_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparator; corrupt_en drops blue on pair 3 to exercise the checker.
    always_comb begin
        cmp_red   = (a_out >= b_out);
        cmp_green = (a_out <= b_out);
        cmp_blue  = (a_out != b_out) && !(corrupt_en && (pair_idx == 4'd3));
    end

    assign leds = {led_r, led_g, led_b};

    function automatic logic [2:0] model(input int p, input logic corrupt);
        int a;
        int b;
        a = p >> 2;
        b = p & 3;
        return {a >= b, a <= b, (a != b) && !(corrupt && (p == 3))};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // mode: 0 plain, 1 corrupted pair 3 with checker, 2 checker cleared at start
    task automatic sweep(input logic hold_start, input int abort_at, input int mode);
        int k;
        int done_cnt;
        int done_at;
        logic aborted;
        logic [2:0] exp_led;
        for (int p = 0; p < NPAIR; p++) sb.push_back(model(p, corrupt_en));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        k = 0;
        done_cnt = 0;
        done_at = -1;
        aborted = 1'b0;
        while (busy && k < 200) begin
            if (k == abort_at) begin
                stop = 1'b1;
                @(posedge clk); #1;
                stop = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_leds", leds, 0);
                check("abort_done", done, 0);
                @(posedge clk); #1;
                check("abort_resume_a", a_out, sw_a);
                aborted = 1'b1;
                break;
            end
            if (k < NPAIR * PAIR_CYC) check("pair_idx", pair_idx, k / PAIR_CYC);
            if ((k % PAIR_CYC) == PAIR_CYC - 1 && k < NPAIR * PAIR_CYC) begin
                exp_led = sb.pop_front();
                check("sweep_led", leds, exp_led);
            end
            if (k == 6 * PAIR_CYC + PAIR_CYC - 1) check("pair6_rgb", leds, 3'b011);
            if (k == 10 * PAIR_CYC + PAIR_CYC - 1) check("pair10_rgb", leds, 3'b110);
            if (done) begin
                done_cnt++;
                done_at = k;
            end
`ifdef CMP_SWEEP_CHECK_EN
            if (mode == 1 && k == 14) check("chk_before", check_err, 0);
            if (mode == 1 && k == 16) check("chk_set", check_err, 1);
            if (mode == 1 && k == SWEEP_CYC - 1) check("chk_sticky", check_err, 1);
            if (mode == 2 && k == 1) check("chk_cleared", check_err, 0);
`endif
            @(posedge clk); #1;
            k++;
        end
        if (aborted) begin
            check("abort_no_done", done_cnt, 0);
            sb.delete();
        end else begin
            check("sweep_len", k, SWEEP_CYC);
            check("done_count", done_cnt, 1);
            check("done_at", done_at, SWEEP_CYC - 1);
            check("sb_empty", sb.size(), 0);
            sb.delete();
        end
        $display("sweep hold=%0d abort_at=%0d mode=%0d cycles=%0d done=%0d", hold_start, abort_at, mode, k, done_cnt);
    endtask

    initial begin
        vecs[0] = '{2'd3, 2'd1, 3'b101};
        vecs[1] = '{2'd1, 2'd2, 3'b011};
        vecs[2] = '{2'd2, 2'd2, 3'b110};
        vecs[3] = '{2'd0, 2'd3, 3'b011};
        vecs[4] = '{2'd3, 2'd0, 3'b101};
        vecs[5] = '{2'd0, 2'd0, 3'b110};

        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        sw_a = 2'd0;
        sw_b = 2'd0;
        corrupt_en = 1'b0;
        #2;
        check("reset_outputs", {a_out, b_out, leds, busy, done, pair_idx}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_idle_busy", busy, 0);

        // Manual mode: operands after one edge, LEDs after two.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sw_a = vecs[i].a;
            sw_b = vecs[i].b;
            @(posedge clk); #1;
            check("manual_a", a_out, vecs[i].a);
            check("manual_b", b_out, vecs[i].b);
            if (i > 0) check("manual_led_lag", leds, vecs[i-1].rgb);
            @(posedge clk); #1;
            check("manual_led", leds, vecs[i].rgb);
            $display("manual a=%0d b=%0d leds=%b", sw_a, sw_b, leds);
        end

        sweep(1'b0, -1, 0);

        // start and stop together in IDLE: stop wins.
        @(negedge clk);
        sw_a = 2'd2;
        sw_b = 2'd1;
        start = 1'b1;
        stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("startstop_busy", busy, 0);
        end
        check("startstop_track", a_out, 2'd2);
        start = 1'b0;
        stop = 1'b0;
        $display("start+stop in idle busy=%0d", busy);

        // start held across the whole sweep: length unchanged, relaunch right after DONE.
        sweep(1'b1, -1, 0);
        @(posedge clk); #1;
        check("relaunch_busy", busy, 1);
        start = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check("relaunch_abort", busy, 0);

        sweep(1'b0, 5 * PAIR_CYC + 2, 0);

`ifdef CMP_SWEEP_CHECK_EN
        corrupt_en = 1'b1;
        sweep(1'b0, -1, 1);
        corrupt_en = 1'b0;
        sweep(1'b0, 20, 2);
`endif

        // Reset asserted in DWELL of pair 2.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {a_out, b_out, leds, busy, done, pair_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_busy", busy, 0);
        check("post_reset_track", a_out, sw_a);
        $display("reset mid-dwell busy=%0d", busy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
